// File: rtl/dice_roll_ctrl.sv
// dice_roll_ctrl: turns a raw push-button and a 1 kHz reference into a dice
// face. The face tumbles while the button is held, slows down after release,
// and then holds a final face of 1..6 with VALID raised.
// Everything runs on CLK50M. CLK1K is only sampled and edge-detected into a
// one-cycle tick, so it never clocks any flop.
`timescale 1ns/1ps
module dice_roll_ctrl #(
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned ROLL_MS     = 50,
  parameter int unsigned SETTLE_MS   = 500
) (
  input  logic       CLK50M,
  input  logic       RSTN,
  input  logic       CLK1K,
  input  logic       BTN,
  output logic [2:0] DICE,
  output logic       ROLLING,
  output logic       VALID
);

  // Terminal counts, written as "last value before the event fires".
  localparam logic [15:0] DEB_LAST    = 16'(DEBOUNCE_MS - 1);
  localparam logic [15:0] ROLL_LAST   = 16'(ROLL_MS - 1);
  localparam logic [15:0] SLOW_LAST   = 16'(2 * ROLL_MS - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_MS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROLL,
    ST_SETTLE,
    ST_SHOW
  } state_t;

  // Synchronizers and edge detection
  logic        clk1k_s1_q, clk1k_s1_d;
  logic        clk1k_s2_q, clk1k_s2_d;
  logic        clk1k_dly_q, clk1k_dly_d;
  logic        btn_s1_q, btn_s1_d;
  logic        btn_s2_q, btn_s2_d;
  logic        tick;

  // Debounce
  logic        btn_db_q, btn_db_d;
  logic        btn_db_prev_q, btn_db_prev_d;
  logic [15:0] deb_cnt_q, deb_cnt_d;
  logic        press;
  logic        btn_release;

  // Free-running face source
  logic [2:0]  rng_q, rng_d;

  // Controller
  state_t      state_q, state_d;
  logic [15:0] ms_cnt_q, ms_cnt_d;
  logic [15:0] slow_cnt_q, slow_cnt_d;
  logic [2:0]  dice_q, dice_d;
  logic        rolling_q, rolling_d;
  logic        valid_q, valid_d;

  // Next values for the synchronizer chains; tick fires once per CLK1K rise.
  always_comb begin
    clk1k_s1_d  = CLK1K;
    clk1k_s2_d  = clk1k_s1_q;
    clk1k_dly_d = clk1k_s2_q;
    btn_s1_d    = BTN;
    btn_s2_d    = btn_s1_q;
    tick        = clk1k_s2_q & ~clk1k_dly_q;
  end

  // Synchronizer and delay flops.
  always_ff @(posedge CLK50M or negedge RSTN) begin
    if (!RSTN) begin
      clk1k_s1_q  <= 1'b0;
      clk1k_s2_q  <= 1'b0;
      clk1k_dly_q <= 1'b0;
      btn_s1_q    <= 1'b0;
      btn_s2_q    <= 1'b0;
    end else begin
      clk1k_s1_q  <= clk1k_s1_d;
      clk1k_s2_q  <= clk1k_s2_d;
      clk1k_dly_q <= clk1k_dly_d;
      btn_s1_q    <= btn_s1_d;
      btn_s2_q    <= btn_s2_d;
    end
  end

  // Debounced level flips only after DEBOUNCE_MS consecutive disagreeing ticks.
  always_comb begin
    btn_db_d      = btn_db_q;
    deb_cnt_d     = deb_cnt_q;
    btn_db_prev_d = btn_db_q;
    if (tick) begin
      if (btn_s2_q != btn_db_q) begin
        if (deb_cnt_q == DEB_LAST) begin
          btn_db_d  = ~btn_db_q;
          deb_cnt_d = '0;
        end else begin
          deb_cnt_d = deb_cnt_q + 16'd1;
        end
      end else begin
        deb_cnt_d = '0;
      end
    end
    press       = btn_db_q & ~btn_db_prev_q;
    btn_release = ~btn_db_q & btn_db_prev_q;
  end

  // Debounce state flops.
  always_ff @(posedge CLK50M or negedge RSTN) begin
    if (!RSTN) begin
      btn_db_q      <= 1'b0;
      btn_db_prev_q <= 1'b0;
      deb_cnt_q     <= '0;
    end else begin
      btn_db_q      <= btn_db_d;
      btn_db_prev_q <= btn_db_prev_d;
      deb_cnt_q     <= deb_cnt_d;
    end
  end

  // Face source cycles 1..6 every clock; any stray value recovers to 1.
  always_comb begin
    if ((rng_q >= 3'd6) || (rng_q == 3'd0)) begin
      rng_d = 3'd1;
    end else begin
      rng_d = rng_q + 3'd1;
    end
  end

  // Face source flop, starts at 1.
  always_ff @(posedge CLK50M or negedge RSTN) begin
    if (!RSTN) begin
      rng_q <= 3'd1;
    end else begin
      rng_q <= rng_d;
    end
  end

  // Controller next state, interval counters and registered output values.
  // slow_cnt tracks ms_cnt modulo 2*ROLL_MS without a divider; both start at
  // zero on SETTLE entry and advance on the same ticks.
  always_comb begin
    state_d    = state_q;
    ms_cnt_d   = tick ? (ms_cnt_q + 16'd1) : ms_cnt_q;
    slow_cnt_d = slow_cnt_q;
    dice_d     = dice_q;

    case (state_q)
      ST_IDLE: begin
        if (press) begin
          state_d = ST_ROLL;
          dice_d  = rng_q;
        end
      end

      ST_ROLL: begin
        if (btn_release) begin
          state_d = ST_SETTLE;
        end else if (tick && (ms_cnt_q == ROLL_LAST)) begin
          dice_d   = rng_q;
          ms_cnt_d = '0;
        end
      end

      ST_SETTLE: begin
        if (tick) begin
          if (ms_cnt_q == SETTLE_LAST) begin
            dice_d  = rng_q;
            state_d = ST_SHOW;
          end else if (slow_cnt_q == SLOW_LAST) begin
            dice_d = rng_q;
          end
          slow_cnt_d = (slow_cnt_q == SLOW_LAST) ? 16'd0 : (slow_cnt_q + 16'd1);
        end
      end

      ST_SHOW: begin
        if (press) begin
          state_d = ST_ROLL;
          dice_d  = rng_q;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_d != state_q) begin
      ms_cnt_d   = '0;
      slow_cnt_d = '0;
    end

    if (state_d == ST_IDLE) begin
      dice_d = 3'd0;
    end

    rolling_d = (state_d == ST_ROLL) || (state_d == ST_SETTLE);
    valid_d   = (state_d == ST_SHOW);
  end

  // Controller state and output registers.
  always_ff @(posedge CLK50M or negedge RSTN) begin
    if (!RSTN) begin
      state_q    <= ST_IDLE;
      ms_cnt_q   <= '0;
      slow_cnt_q <= '0;
      dice_q     <= 3'd0;
      rolling_q  <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ms_cnt_q   <= ms_cnt_d;
      slow_cnt_q <= slow_cnt_d;
      dice_q     <= dice_d;
      rolling_q  <= rolling_d;
      valid_q    <= valid_d;
    end
  end

  assign DICE    = dice_q;
  assign ROLLING = rolling_q;
  assign VALID   = valid_q;

endmodule

// File: tb/tb_dice_roll_ctrl.sv
// tb_dice_roll_ctrl: directed scenarios for dice_roll_ctrl with a shortened
// tick period (11 CLK50M cycles, coprime with the 6-step face source).
`timescale 1ns/1ps
module tb_dice_roll_ctrl;

  localparam int DEB    = 4;
  localparam int RMS    = 2;
  localparam int SMS    = 10;
  localparam int NROLLS = 150;

  logic       CLK50M = 1'b0;
  logic       RSTN   = 1'b0;
  logic       CLK1K  = 1'b0;
  logic       BTN    = 1'b0;
  logic [2:0] DICE;
  logic       ROLLING;
  logic       VALID;

  int         checks   = 0;
  int         failures = 0;
  logic [2:0] rng_model = 3'd1;
  logic [2:0] saved;
  int         face_hist [7];
  logic       bad_valid_seen = 1'b0;

  dice_roll_ctrl #(
    .DEBOUNCE_MS(DEB),
    .ROLL_MS    (RMS),
    .SETTLE_MS  (SMS)
  ) dut (
    .CLK50M (CLK50M),
    .RSTN   (RSTN),
    .CLK1K  (CLK1K),
    .BTN    (BTN),
    .DICE   (DICE),
    .ROLLING(ROLLING),
    .VALID  (VALID)
  );

  // 50 MHz system clock
  always #10 CLK50M = ~CLK50M;

  // Tick reference, edges offset so they never coincide with CLK50M edges
  initial begin
    #5;
    forever #110 CLK1K = ~CLK1K;
  end

  // Expected face source: 1..6 advancing every clock, back to 1 on reset
  always @(posedge CLK50M or negedge RSTN) begin
    if (!RSTN) rng_model <= 3'd1;
    else       rng_model <= (rng_model == 3'd6) ? 3'd1 : rng_model + 3'd1;
  end

  // Sticky flag for an illegal face shown while VALID is high
  always @(negedge CLK50M) begin
    if (RSTN && VALID === 1'b1 && (DICE === 3'd0 || DICE === 3'd7)) bad_valid_seen = 1'b1;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

  // Face captured by the DUT on the edge just sampled
  function automatic logic [2:0] prev_face(input logic [2:0] f);
    return (f == 3'd1) ? 3'd6 : f - 3'd1;
  endfunction

  // Advance to 1 ns after the clock edge that acts on the n-th next tick
  task automatic after_tick(input int n);
    repeat (n) begin
      @(posedge CLK1K);
      repeat (3) @(posedge CLK50M);
    end
    #1;
  endtask

  task automatic test_reset;
    RSTN = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK50M);
      BTN = i[0];
    end
    checks++;
    if ({ROLLING, VALID, DICE} !== 5'b0) begin
      failures++;
      $display("[TB] FAIL reset_hold: got R=%b V=%b D=%0d expected 0 0 0", ROLLING, VALID, DICE);
    end
    @(negedge CLK50M);
    BTN  = 1'b0;
    RSTN = 1'b1;
    checks++;
    if ({ROLLING, VALID, DICE} !== 5'b0) begin
      failures++;
      $display("[TB] FAIL reset_release: got R=%b V=%b D=%0d expected 0 0 0", ROLLING, VALID, DICE);
    end
    after_tick(2);
    checks++;
    if ({ROLLING, VALID, DICE} !== 5'b0) begin
      failures++;
      $display("[TB] FAIL reset_after: got R=%b V=%b D=%0d expected 0 0 0", ROLLING, VALID, DICE);
    end
  endtask

  task automatic test_bounce;
    after_tick(1);
    @(negedge CLK50M) BTN = 1'b1;
    after_tick(DEB - 1);
    checks++;
    if ({ROLLING, VALID, DICE} !== 5'b0) begin
      failures++;
      $display("[TB] FAIL bounce_high1: got R=%b V=%b D=%0d expected 0 0 0", ROLLING, VALID, DICE);
    end
    @(negedge CLK50M) BTN = 1'b0;
    after_tick(1);
    @(negedge CLK50M) BTN = 1'b1;
    after_tick(DEB - 1);
    checks++;
    if ({ROLLING, VALID, DICE} !== 5'b0) begin
      failures++;
      $display("[TB] FAIL bounce_high2: got R=%b V=%b D=%0d expected 0 0 0", ROLLING, VALID, DICE);
    end
    @(negedge CLK50M) BTN = 1'b0;
    after_tick(DEB + 1);
    checks++;
    if ({ROLLING, VALID, DICE} !== 5'b0) begin
      failures++;
      $display("[TB] FAIL bounce_end: got R=%b V=%b D=%0d expected 0 0 0", ROLLING, VALID, DICE);
    end
  endtask

  task automatic test_clean_roll;
    after_tick(1);
    @(negedge CLK50M) BTN = 1'b1;
    after_tick(DEB - 1);
    checks++;
    if (ROLLING !== 1'b0) begin
      failures++;
      $display("[TB] FAIL press_early: got ROLLING=%b expected 0", ROLLING);
    end
    @(posedge CLK1K);
    repeat (3) @(posedge CLK50M);
    #1;
    checks++;
    if ({ROLLING, VALID} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL press_tick_edge: got R=%b V=%b expected 0 0", ROLLING, VALID);
    end
    @(posedge CLK50M);
    #1;
    saved = prev_face(rng_model);
    checks++;
    if ({ROLLING, VALID, DICE} !== {2'b10, saved}) begin
      failures++;
      $display("[TB] FAIL press_rolling: got R=%b V=%b D=%0d expected 1 0 %0d", ROLLING, VALID, DICE, saved);
    end
    for (int k = 1; k <= 30; k++) begin
      after_tick(1);
      if (k % 2 == 0) saved = prev_face(rng_model);
      checks++;
      if ({ROLLING, VALID, DICE} !== {2'b10, saved}) begin
        failures++;
        $display("[TB] FAIL roll_update k=%0d: got R=%b V=%b D=%0d expected 1 0 %0d", k, ROLLING, VALID, DICE, saved);
      end
      if (k == 26) begin
        @(negedge CLK50M) BTN = 1'b0;
      end
    end
    @(posedge CLK50M);
    #1;
    checks++;
    if ({ROLLING, VALID, DICE} !== {2'b10, saved}) begin
      failures++;
      $display("[TB] FAIL settle_entry: got R=%b V=%b D=%0d expected 1 0 %0d", ROLLING, VALID, DICE, saved);
    end
    for (int j = 1; j <= SMS; j++) begin
      after_tick(1);
      if (j == 4 || j == 8 || j == SMS) saved = prev_face(rng_model);
      checks++;
      if ({ROLLING, VALID, DICE} !== {(j < SMS) ? 2'b10 : 2'b01, saved}) begin
        failures++;
        $display("[TB] FAIL settle_step j=%0d: got R=%b V=%b D=%0d expected D=%0d", j, ROLLING, VALID, DICE, saved);
      end
    end
    after_tick(3);
    checks++;
    if ({ROLLING, VALID, DICE} !== {2'b01, saved}) begin
      failures++;
      $display("[TB] FAIL show_stable: got R=%b V=%b D=%0d expected 0 1 %0d", ROLLING, VALID, DICE, saved);
    end
  endtask

  task automatic test_reroll_from_show;
    @(negedge CLK50M) BTN = 1'b1;
    after_tick(DEB - 1);
    @(posedge CLK1K);
    repeat (3) @(posedge CLK50M);
    #1;
    checks++;
    if ({ROLLING, VALID} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL reroll_before: got R=%b V=%b expected 0 1", ROLLING, VALID);
    end
    @(posedge CLK50M);
    #1;
    saved = prev_face(rng_model);
    checks++;
    if ({ROLLING, VALID, DICE} !== {2'b10, saved}) begin
      failures++;
      $display("[TB] FAIL reroll_edge: got R=%b V=%b D=%0d expected 1 0 %0d", ROLLING, VALID, DICE, saved);
    end
    after_tick(3);
    @(negedge CLK50M) BTN = 1'b0;
    after_tick(DEB);
    @(posedge CLK50M);
    #1;
    checks++;
    if ({ROLLING, VALID} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL reroll_settle: got R=%b V=%b expected 1 0", ROLLING, VALID);
    end
  endtask

  task automatic test_press_during_settle;
    after_tick(3);
    @(negedge CLK50M) BTN = 1'b1;
    after_tick(DEB);
    @(posedge CLK50M);
    #1;
    checks++;
    if ({ROLLING, VALID} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL settle_press: got R=%b V=%b expected 1 0", ROLLING, VALID);
    end
    after_tick(3);
    saved = prev_face(rng_model);
    checks++;
    if ({ROLLING, VALID, DICE} !== {2'b01, saved}) begin
      failures++;
      $display("[TB] FAIL settle_show: got R=%b V=%b D=%0d expected 0 1 %0d", ROLLING, VALID, DICE, saved);
    end
    after_tick(6);
    checks++;
    if ({ROLLING, VALID, DICE} !== {2'b01, saved}) begin
      failures++;
      $display("[TB] FAIL held_no_roll: got R=%b V=%b D=%0d expected 0 1 %0d", ROLLING, VALID, DICE, saved);
    end
    @(negedge CLK50M) BTN = 1'b0;
    after_tick(DEB + 1);
    checks++;
    if ({ROLLING, VALID, DICE} !== {2'b01, saved}) begin
      failures++;
      $display("[TB] FAIL release_in_show: got R=%b V=%b D=%0d expected 0 1 %0d", ROLLING, VALID, DICE, saved);
    end
    @(negedge CLK50M) BTN = 1'b1;
    after_tick(DEB);
    @(posedge CLK50M);
    #1;
    saved = prev_face(rng_model);
    checks++;
    if ({ROLLING, VALID, DICE} !== {2'b10, saved}) begin
      failures++;
      $display("[TB] FAIL repress_roll: got R=%b V=%b D=%0d expected 1 0 %0d", ROLLING, VALID, DICE, saved);
    end
    after_tick(2);
    @(negedge CLK50M) BTN = 1'b0;
    after_tick(DEB);
    @(posedge CLK50M);
    #1;
  endtask

  task automatic test_reset_mid_settle;
    int n;
    after_tick(2);
    @(negedge CLK50M) RSTN = 1'b0;
    #1;
    checks++;
    if ({ROLLING, VALID, DICE} !== 5'b0) begin
      failures++;
      $display("[TB] FAIL reset_async: got R=%b V=%b D=%0d expected 0 0 0", ROLLING, VALID, DICE);
    end
    @(negedge CLK50M) RSTN = 1'b1;
    after_tick(2);
    checks++;
    if ({ROLLING, VALID, DICE} !== 5'b0) begin
      failures++;
      $display("[TB] FAIL reset_idle: got R=%b V=%b D=%0d expected 0 0 0", ROLLING, VALID, DICE);
    end
    @(negedge CLK50M) BTN = 1'b1;
    after_tick(DEB);
    @(posedge CLK50M);
    #1;
    saved = prev_face(rng_model);
    checks++;
    if ({ROLLING, VALID, DICE} !== {2'b10, saved}) begin
      failures++;
      $display("[TB] FAIL reset_press: got R=%b V=%b D=%0d expected 1 0 %0d", ROLLING, VALID, DICE, saved);
    end
    @(negedge CLK50M) BTN = 1'b0;
    n = 0;
    while (VALID !== 1'b1 && n < 600) begin
      @(negedge CLK50M);
      n++;
    end
    checks++;
    if (VALID !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_roll_done: got VALID=%b expected 1 within 600 cycles", VALID);
    end
  endtask

  task automatic test_distribution;
    int n;
    for (int f = 0; f < 7; f++) face_hist[f] = 0;
    for (int r = 0; r < NROLLS; r++) begin
      @(negedge CLK50M) BTN = 1'b1;
      n = 0;
      while (ROLLING !== 1'b1 && n < 300) begin
        @(negedge CLK50M);
        n++;
      end
      checks++;
      if (ROLLING !== 1'b1) begin
        failures++;
        $display("[TB] FAIL dist_roll r=%0d: got ROLLING=%b expected 1 within 300 cycles", r, ROLLING);
      end
      after_tick(int'($urandom_range(1, 8)));
      @(negedge CLK50M) BTN = 1'b0;
      n = 0;
      while (VALID !== 1'b1 && n < 600) begin
        @(negedge CLK50M);
        n++;
      end
      checks++;
      if (VALID !== 1'b1 || DICE < 3'd1 || DICE > 3'd6) begin
        failures++;
        $display("[TB] FAIL dist_valid r=%0d: got VALID=%b DICE=%0d expected 1 and 1..6", r, VALID, DICE);
      end else begin
        face_hist[DICE]++;
      end
    end
    for (int f = 1; f <= 6; f++) begin
      checks++;
      if (face_hist[f] == 0) begin
        failures++;
        $display("[TB] FAIL dist_face%0d: got count 0 expected >0", f);
      end
    end
    checks++;
    if (bad_valid_seen !== 1'b0) begin
      failures++;
      $display("[TB] FAIL valid_face_range: got illegal face with VALID=1 expected none");
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_clean_roll();
    test_reroll_from_show();
    test_press_during_settle();
    test_reset_mid_settle();
    test_distribution();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
